pseudo_ana_stk_n: RTL
=====================

Name: pseudo_ana_stk_n

Overview:
- Generalised digital-to-analog stick emulator: converts per-axis digital direction inputs (D-pad or keyboard) into unsigned analog positions for the game core's analog inputs.
- Supports N axes and parametrised output width, limit, step and return-to-centre rate.
- Adds a held-direction acceleration ramp, a per-axis hold (position) mode and a global recentre.
- Sits between the input-merging logic and the core's AX/AY inputs. Updates once per frame tick.

Parameters:
- NAXIS, 2, number of independent axes.
- W, 8, output width per axis in bits.
- CENTER, 127, output code for rest position.
- LIMIT, 120, maximum magnitude of signed displacement.
- STEP_MIN, 15, displacement step on the first tick of a press, and after any direction change.
- STEP_MAX, 15, ceiling of the accelerated step.
- ACCEL, 0, step increment per consecutive held tick (0 = constant step).
- DECAY, 15, return-to-centre step per tick in spring mode.
- Elaboration must fail unless all of the following hold:
  - LIMIT <= CENTER
  - CENTER+LIMIT <= 2^W-1
  - 1 <= STEP_MIN <= STEP_MAX <= LIMIT
  - DECAY >= 1

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  update strobe (frame-rate level or pulse); one update per 0->1 transition.
- NEG  in  NAXIS  per-axis press toward the negative direction (left/up).
- POS  in  NAXIS  per-axis press toward the positive direction (right/down).
- HOLD  in  NAXIS  per-axis mode: 0 = spring (decays to centre), 1 = hold (position retained on release).
- RECENTER  in  1  synchronous clear of all axes to centre.
- AOUT  out  NAXIS*W  axis i on bits [i*W +: W], unsigned, equals CENTER+pos_i.
- ACTIVE  out  NAXIS  bit i = 1 when pos_i != 0.

Behaviour:
- Internal state per axis:
  - pos_i: signed, W+2 bits.
  - step_i: unsigned, W bits.
  - ldir_i: last direction, one of {-1, 0, +1}.
  - Shared: tick_prev register.
- Reset (RESET=1 at a clock edge):
  - pos=0, step=STEP_MIN, ldir=0.
  - tick_prev=1, so a TICK held high through reset release does not cause an update.
  - AOUT = CENTER for every axis; ACTIVE = 0.
  - Reset overrides all other inputs.
- upd = TICK & ~tick_prev. tick_prev <= TICK every cycle.
- Priority order: RESET > RECENTER > upd.
  - RECENTER=1: pos=0, step=STEP_MIN, ldir=0 on all axes. A coincident upd is discarded.
- Direction, per axis on upd: dir = +1 if POS&~NEG, -1 if NEG&~POS, otherwise 0. Both pressed counts as released.
- dir != 0 and dir == ldir:
  - pos += dir*step.
  - step <= min(step+ACCEL, STEP_MAX).
- dir != 0 and dir != ldir (new press or reversal):
  - pos += dir*STEP_MIN.
  - step <= min(STEP_MIN+ACCEL, STEP_MAX).
  - ldir <= dir.
- dir == 0:
  - ldir=0, step=STEP_MIN.
  - HOLD=1: pos unchanged.
  - HOLD=0: if |pos| <= DECAY then pos=0, otherwise pos moves DECAY toward 0. There is never overshoot or oscillation.
- Clamping:
  - After every move, pos is saturated to [-LIMIT, +LIMIT].
  - Intermediate sums use W+2 bits, so no wrap-around is possible.
- Output registers:
  - AOUT and ACTIVE are registered from pos.
  - Latency: TICK first sampled high at edge k, pos updated at edge k, AOUT/ACTIVE reflect it from edge k+1.
  - Same latency for RECENTER.
- Timing rules:
  - TICK held high for many cycles yields exactly one update.
  - Inputs are sampled only at the upd cycle; presses between ticks are ignored.
- HOLD change: takes effect at the next upd. pos is not altered at the moment HOLD changes.
- Axes are fully independent and are updated in the same cycle.

Test Plan:
- Reset and tick masking: RESET with TICK=1 held across release -> AOUT=127 on all axes, ACTIVE=0, no update until TICK falls and rises again.
- Saturation (defaults): POS[0]=1 for 9 ticks -> AOUT[0] steps 142,157,172,187,202,217,232,247,247. Axis 1 stays 127. ACTIVE=01.
- Spring decay without overshoot:
  - Defaults: release from 247 -> eight ticks down to 127.
  - DECAY=10 and pos=+15: release -> 132 then 127, remaining 127.
- Acceleration and reversal:
  - Setup: STEP_MIN=2, ACCEL=2, STEP_MAX=8.
  - Hold POS for 5 ticks -> pos 2,6,12,20,28.
  - Switch to NEG -> pos 26, then 22, then 16.
- Hold mode and both pressed:
  - HOLD[1]=1, NEG[1] for 3 ticks -> AOUT[1]=82. Release -> stays 82 over 4 ticks.
  - With HOLD[1]=0 and NEG&POS both pressed -> decays as if released.
- RECENTER coincident with TICK rising while POS held -> pos=0, AOUT=127 one cycle later, ACTIVE=0. The next tick applies STEP_MIN.

Source files
------------

// File: rtl/pseudo_ana_stk_n.sv
// Digital-to-analog stick emulator: per-axis direction presses become unsigned
// analog positions around CENTER, with an acceleration ramp, hold mode and recentre.
module pseudo_ana_stk_n #(
    parameter int NAXIS    = 2,
    parameter int W        = 8,
    parameter int CENTER   = 127,
    parameter int LIMIT    = 120,
    parameter int STEP_MIN = 15,
    parameter int STEP_MAX = 15,
    parameter int ACCEL    = 0,
    parameter int DECAY    = 15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 TICK,
    input  logic [NAXIS-1:0]     NEG,
    input  logic [NAXIS-1:0]     POS,
    input  logic [NAXIS-1:0]     HOLD,
    input  logic                 RECENTER,
    output logic [NAXIS*W-1:0]   AOUT,
    output logic [NAXIS-1:0]     ACTIVE
);

    localparam int PW = W + 2;

    typedef logic signed [PW-1:0] pos_t;

    if (!(LIMIT <= CENTER) || !(CENTER + LIMIT <= (2**W) - 1) ||
        !(1 <= STEP_MIN) || !(STEP_MIN <= STEP_MAX) || !(STEP_MAX <= LIMIT) ||
        !(DECAY >= 1)) begin : g_param_check
        $error("pseudo_ana_stk_n: illegal parameter combination");
    end

    function automatic pos_t sat_pos(input int v);
        if (v > LIMIT) begin
            return PW'(LIMIT);
        end else if (v < -LIMIT) begin
            return PW'(-LIMIT);
        end
        return PW'(v);
    endfunction

    function automatic logic [W-1:0] accel_step(input int s);
        int t;
        t = s + ACCEL;
        if (t > STEP_MAX) begin
            t = STEP_MAX;
        end
        return W'(t);
    endfunction

    // Moves toward zero by DECAY, landing exactly on zero rather than crossing it.
    function automatic int decay_pos(input int p);
        if (p <= DECAY && p >= -DECAY) begin
            return 0;
        end else if (p > 0) begin
            return p - DECAY;
        end
        return p + DECAY;
    endfunction

    pos_t                  pos_q      [NAXIS];
    pos_t                  pos_d      [NAXIS];
    logic [W-1:0]          step_q     [NAXIS];
    logic [W-1:0]          step_d     [NAXIS];
    logic signed [1:0]     ldir_q     [NAXIS];
    logic signed [1:0]     ldir_d     [NAXIS];
    logic                  tick_prev_q;
    logic                  tick_prev_d;
    logic [NAXIS*W-1:0]    aout_q;
    logic [NAXIS*W-1:0]    aout_d;
    logic [NAXIS-1:0]      active_q;
    logic [NAXIS-1:0]      active_d;
    logic                  upd;

    always_comb begin
        int p;
        int dir;
        p           = 0;
        dir         = 0;
        tick_prev_d = TICK;
        upd         = TICK & ~tick_prev_q;
        aout_d      = '0;
        active_d    = '0;
        for (int i = 0; i < NAXIS; i++) begin
            pos_d[i]  = pos_q[i];
            step_d[i] = step_q[i];
            ldir_d[i] = ldir_q[i];
            p         = int'(pos_q[i]);
            dir       = 0;
            if (RECENTER) begin
                pos_d[i]  = '0;
                step_d[i] = W'(STEP_MIN);
                ldir_d[i] = '0;
            end else if (upd) begin
                if (POS[i] && !NEG[i]) begin
                    dir = 1;
                end else if (NEG[i] && !POS[i]) begin
                    dir = -1;
                end
                if (dir != 0 && dir == int'(ldir_q[i])) begin
                    pos_d[i]  = sat_pos(p + dir * int'(step_q[i]));
                    step_d[i] = accel_step(int'(step_q[i]));
                end else if (dir != 0) begin
                    // New press or reversal restarts the ramp from the minimum step.
                    pos_d[i]  = sat_pos(p + dir * STEP_MIN);
                    step_d[i] = accel_step(STEP_MIN);
                    ldir_d[i] = 2'(dir);
                end else begin
                    step_d[i] = W'(STEP_MIN);
                    ldir_d[i] = '0;
                    if (!HOLD[i]) begin
                        pos_d[i] = sat_pos(decay_pos(p));
                    end
                end
            end
            aout_d[i*W +: W] = W'(CENTER + int'(pos_q[i]));
            active_d[i]      = (pos_q[i] != '0);
        end
    end

    // tick_prev resets high so a TICK held through reset release is not an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_prev_q <= 1'b1;
            active_q    <= '0;
            for (int i = 0; i < NAXIS; i++) begin
                pos_q[i]            <= '0;
                step_q[i]           <= W'(STEP_MIN);
                ldir_q[i]           <= '0;
                aout_q[i*W +: W]    <= W'(CENTER);
            end
        end else begin
            tick_prev_q <= tick_prev_d;
            aout_q      <= aout_d;
            active_q    <= active_d;
            for (int i = 0; i < NAXIS; i++) begin
                pos_q[i]  <= pos_d[i];
                step_q[i] <= step_d[i];
                ldir_q[i] <= ldir_d[i];
            end
        end
    end

    assign AOUT   = aout_q;
    assign ACTIVE = active_q;

endmodule
